// File: rtl/seg_capture.sv
// seg_capture: oversampling receiver for the serial 7-segment display stream.
// Define SEG_CAPTURE_ERR_EN to enable the sticky error flags and err_clr.
module seg_capture #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SER,
    input  logic        SCLK,
    input  logic        RCLK,
    input  logic [3:0]  SEL,
    input  logic        err_clr,
    output logic [7:0]  seg_raw,
    output logic [3:0]  digit,
    output logic [1:0]  digit_pos,
    output logic        digit_valid,
    output logic [15:0] disnum,
    output logic        frame_valid,
    output logic [2:0]  err
);

    logic [SYNC_STAGES-1:0]      ser_q, sclk_q, rclk_q;
    logic [SYNC_STAGES-1:0][3:0] sel_q;
    logic                        sclk_d, rclk_d;
    logic                        ser_s, sclk_s, rclk_s;
    logic [3:0]                  sel_s;
    logic                        sclk_rise, rclk_rise;

    logic [7:0] sr;
    logic [3:0] bit_cnt;
    logic       lat_go;
    logic [7:0] lat_sr;
    logic [3:0] lat_sel;
    logic [3:0] lat_cnt;

    logic [3:0] seen;
    logic [3:0] new_mask;
    logic [3:0] dec_code;
    logic       dec_bad;
    logic       sel_ok;
    logic [1:0] sel_pos;
    logic       upd;

    assign ser_s     = ser_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_q[SYNC_STAGES-1];
    assign rclk_s    = rclk_q[SYNC_STAGES-1];
    assign sel_s     = sel_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign rclk_rise = rclk_s & ~rclk_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ser_q  <= '0;
            sclk_q <= '0;
            rclk_q <= '0;
            sel_q  <= '0;
            sclk_d <= 1'b0;
            rclk_d <= 1'b0;
        end else begin
            ser_q  <= {ser_q[SYNC_STAGES-2:0], SER};
            sclk_q <= {sclk_q[SYNC_STAGES-2:0], SCLK};
            rclk_q <= {rclk_q[SYNC_STAGES-2:0], RCLK};
            sel_q  <= {sel_q[SYNC_STAGES-2:0], SEL};
            sclk_d <= sclk_s;
            rclk_d <= rclk_s;
        end
    end

    // The latch snapshots the pre-shift byte even when both edges coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr      <= '0;
            bit_cnt <= '0;
            lat_go  <= 1'b0;
            lat_sr  <= '0;
            lat_sel <= '0;
            lat_cnt <= '0;
        end else begin
            lat_go <= rclk_rise;
            if (rclk_rise) begin
                lat_sr  <= sr;
                lat_sel <= sel_s;
                lat_cnt <= bit_cnt;
            end
            if (sclk_rise) begin
                sr <= {ser_s, sr[7:1]};
                if (rclk_rise)
                    bit_cnt <= 4'd1;
                else if (bit_cnt != 4'hF)
                    bit_cnt <= bit_cnt + 4'd1;
            end else if (rclk_rise) begin
                bit_cnt <= '0;
            end
        end
    end

    always_comb begin
        dec_code = 4'hF;
        dec_bad  = 1'b0;
        case (lat_sr)
            8'hFC:   dec_code = 4'h0;
            8'h60:   dec_code = 4'h1;
            8'hDA:   dec_code = 4'h2;
            8'hF2:   dec_code = 4'h3;
            8'h66:   dec_code = 4'h4;
            8'hB6:   dec_code = 4'h5;
            8'hBE:   dec_code = 4'h6;
            8'hE0:   dec_code = 4'h7;
            8'hFE:   dec_code = 4'h8;
            8'hF6:   dec_code = 4'h9;
            8'hEE:   dec_code = 4'hA;
            8'h6E:   dec_code = 4'hB;
            8'h9C:   dec_code = 4'hC;
            8'h00:   dec_code = 4'hF;
            default: dec_bad  = 1'b1;
        endcase
    end

    always_comb begin
        sel_ok  = 1'b1;
        sel_pos = 2'd0;
        case (lat_sel)
            4'b1110: sel_pos = 2'd0;
            4'b1101: sel_pos = 2'd1;
            4'b1011: sel_pos = 2'd2;
            4'b0111: sel_pos = 2'd3;
            default: sel_ok  = 1'b0;
        endcase
    end

    assign new_mask = seen | (4'b0001 << sel_pos);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_raw     <= '0;
            digit       <= '0;
            digit_pos   <= '0;
            digit_valid <= 1'b0;
            disnum      <= '0;
            frame_valid <= 1'b0;
            seen        <= '0;
        end else begin
            digit_valid <= 1'b0;
            frame_valid <= 1'b0;
            if (lat_go) begin
                seg_raw <= lat_sr;
                digit   <= dec_code;
                if (upd) begin
                    digit_pos                       <= sel_pos;
                    disnum[{sel_pos, 2'b00} +: 4]   <= dec_code;
                    digit_valid                     <= 1'b1;
                    if (new_mask == 4'hF) begin
                        frame_valid <= 1'b1;
                        seen        <= '0;
                    end else begin
                        seen <= new_mask;
                    end
                end
            end
        end
    end

`ifdef SEG_CAPTURE_ERR_EN
    assign upd = sel_ok;

    // A new error outranks a coincident clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err <= '0;
        else
            err <= (err & ~{3{err_clr}})
                 | ({3{lat_go}} & {~sel_ok, dec_bad, lat_cnt != 4'd8});
    end
`else
    assign upd = 1'b1;
    assign err = '0;

    logic unused_err;
    assign unused_err = ^{err_clr, dec_bad, sel_ok, lat_cnt};
`endif

endmodule

// File: tb/tb_seg_capture.sv
// tb_seg_capture: vector table, directed corner cases and randomized
// traffic checked against a byte/position-level model of the receiver.
module tb_seg_capture;

`ifdef SEG_CAPTURE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        SER, SCLK, RCLK, err_clr;
    logic [3:0]  SEL;
    logic [7:0]  seg_raw;
    logic [3:0]  digit;
    logic [1:0]  digit_pos;
    logic        digit_valid;
    logic [15:0] disnum;
    logic        frame_valid;
    logic [2:0]  err;

    always #5 clk = ~clk;

    seg_capture #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .SER(SER), .SCLK(SCLK), .RCLK(RCLK),
        .SEL(SEL), .err_clr(err_clr), .seg_raw(seg_raw), .digit(digit),
        .digit_pos(digit_pos), .digit_valid(digit_valid), .disnum(disnum),
        .frame_valid(frame_valid), .err(err)
    );

    int checks = 0;
    int failures = 0;
    int dv_cnt = 0;
    int fv_cnt = 0;

    logic [7:0] pats [14] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE,
                              8'hE0, 8'hFE, 8'hF6, 8'hEE, 8'h6E, 8'h9C, 8'h00};

    // model state
    logic [7:0]  m_sr;
    int          m_cnt;
    logic [15:0] m_disnum;
    logic [3:0]  m_mask;
    logic [1:0]  m_pos;
    logic [3:0]  m_digit;
    logic [7:0]  m_seg;
    logic [2:0]  m_err;
    int          m_dv_cnt, m_fv_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (digit_valid) dv_cnt++;
        if (frame_valid) begin
            fv_cnt++;
            chk("frame_with_dv", {31'd0, digit_valid}, 32'd1);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic m_reset();
        m_sr = 0; m_cnt = 0; m_disnum = 0; m_mask = 0;
        m_pos = 0; m_digit = 0; m_seg = 0; m_err = 0;
    endtask

    task automatic m_shift(input logic b);
        m_sr = {b, m_sr[7:1]};
        if (m_cnt < 15) m_cnt++;
    endtask

    task automatic m_decode(input logic [7:0] b, output logic [3:0] c, output logic bad);
        c = 4'hF;
        bad = 1'b1;
        for (int i = 0; i < 14; i++)
            if (b == pats[i]) begin
                c = (i == 13) ? 4'hF : 4'(i);
                bad = 1'b0;
            end
    endtask

    task automatic m_latch(input logic [3:0] sel, output logic dv, output logic fv);
        logic [3:0] c, nsel;
        logic bad, ok;
        int pos;
        m_decode(m_sr, c, bad);
        nsel = ~sel;
        ok = ($countones(nsel) == 1);
        pos = 0;
        for (int i = 0; i < 4; i++) if (nsel[i]) pos = i;
        m_seg = m_sr;
        m_digit = c;
        if (ERR_EN) begin
            if (!ok) m_err[2] = 1'b1;
            if (bad) m_err[1] = 1'b1;
            if (m_cnt != 8) m_err[0] = 1'b1;
        end else if (!ok) begin
            ok = 1'b1;
            pos = 0;
        end
        dv = ok;
        fv = 1'b0;
        if (ok) begin
            m_pos = 2'(pos);
            m_disnum[pos*4 +: 4] = c;
            m_mask[pos] = 1'b1;
            m_dv_cnt++;
            if (m_mask == 4'hF) begin
                fv = 1'b1;
                m_mask = 0;
                m_fv_cnt++;
            end
        end
        m_cnt = 0;
    endtask

    task automatic shift_bit(input logic b);
        @(negedge clk);
        SER = b;
        SCLK = 1'b0;
        repeat (4) @(negedge clk);
        SCLK = 1'b1;
        m_shift(b);
        repeat (4) @(negedge clk);
        SCLK = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++)
            shift_bit(i < 8 ? v[i] : 1'($urandom));
    endtask

    task automatic check_outputs(input string tag);
        chk($sformatf("%s.seg_raw", tag), 32'(seg_raw), 32'(m_seg));
        chk($sformatf("%s.digit", tag), 32'(digit), 32'(m_digit));
        chk($sformatf("%s.digit_pos", tag), 32'(digit_pos), 32'(m_pos));
        chk($sformatf("%s.disnum", tag), 32'(disnum), 32'(m_disnum));
        chk($sformatf("%s.err", tag), 32'(err), 32'(m_err));
    endtask

    task automatic do_latch(input logic [3:0] sel, input bit with_shift,
                            input logic b, input string tag);
        logic dv, fv;
        @(negedge clk);
        SEL = sel;
        SER = b;
        repeat (4) @(negedge clk);
        m_latch(sel, dv, fv);
        if (with_shift) m_shift(b);
        RCLK = 1'b1;
        if (with_shift) SCLK = 1'b1;
        repeat (3) @(negedge clk);
        chk($sformatf("%s.dv_early", tag), 32'(digit_valid), 32'd0);
        if (with_shift) chk($sformatf("%s.bit_cnt", tag), 32'(dut.bit_cnt), 32'd1);
        @(negedge clk);
        chk($sformatf("%s.dv", tag), 32'(digit_valid), 32'(dv));
        chk($sformatf("%s.fv", tag), 32'(frame_valid), 32'(fv));
        check_outputs(tag);
        @(negedge clk);
        chk($sformatf("%s.dv_pulse", tag), 32'(digit_valid), 32'd0);
        RCLK = 1'b0;
        SCLK = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic reset_dut(input string tag);
        @(negedge clk);
        rst = 1'b1;
        SCLK = 1'b0;
        RCLK = 1'b0;
        repeat (3) @(negedge clk);
        m_reset();
        check_outputs(tag);
        chk($sformatf("%s.dv", tag), 32'(digit_valid), 32'd0);
        chk($sformatf("%s.fv", tag), 32'(frame_valid), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_err = 0;
        @(negedge clk);
        chk("err_clr", 32'(err), 32'(m_err));
    endtask

    typedef struct {
        logic [7:0]  pat;
        logic [3:0]  sel;
        logic [3:0]  dig;
        logic [1:0]  pos;
        logic [15:0] dn;
        int          fr;
    } vec_t;

    vec_t tbl [11];

    initial begin
        int f0, d0;
        logic [15:0] saved;
        logic [7:0] pat;
        logic [3:0] sel;
        int nb;
        bit ws;

        tbl[0]  = '{8'hB6, 4'b1011, 4'h5, 2'd2, 16'h0500, 0};
        tbl[1]  = '{8'h60, 4'b1110, 4'h1, 2'd0, 16'h0501, 0};
        tbl[2]  = '{8'hDA, 4'b1101, 4'h2, 2'd1, 16'h0521, 0};
        tbl[3]  = '{8'hF2, 4'b1011, 4'h3, 2'd2, 16'h0321, 0};
        tbl[4]  = '{8'h66, 4'b0111, 4'h4, 2'd3, 16'h4321, 1};
        tbl[5]  = '{8'hFC, 4'b1110, 4'h0, 2'd0, 16'h4320, 0};
        tbl[6]  = '{8'hEE, 4'b1101, 4'hA, 2'd1, 16'h43A0, 0};
        tbl[7]  = '{8'h9C, 4'b0111, 4'hC, 2'd3, 16'hC3A0, 0};
        tbl[8]  = '{8'h00, 4'b1011, 4'hF, 2'd2, 16'hCFA0, 1};
        tbl[9]  = '{8'h6E, 4'b1110, 4'hB, 2'd0, 16'hCFAB, 0};
        tbl[10] = '{8'h81, 4'b1110, 4'hF, 2'd0, 16'hCFAF, 0};

        rst = 1'b1;
        SER = 1'b0; SCLK = 1'b0; RCLK = 1'b0; SEL = 4'hF; err_clr = 1'b0;
        m_dv_cnt = 0;
        m_fv_cnt = 0;
        reset_dut("reset");

        for (int i = 0; i < 11; i++) begin
            f0 = fv_cnt;
            d0 = dv_cnt;
            send_bits(tbl[i].pat, 8);
            do_latch(tbl[i].sel, 1'b0, 1'b0, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.tbl_digit", i), 32'(digit), 32'(tbl[i].dig));
            chk($sformatf("vec%0d.tbl_pos", i), 32'(digit_pos), 32'(tbl[i].pos));
            chk($sformatf("vec%0d.tbl_disnum", i), 32'(disnum), 32'(tbl[i].dn));
            chk($sformatf("vec%0d.tbl_frames", i), 32'(fv_cnt - f0), 32'(tbl[i].fr));
            chk($sformatf("vec%0d.tbl_dvs", i), 32'(dv_cnt - d0), 32'd1);
        end

        // short byte, then clear
        reset_dut("reset2");
        send_bits(8'hFF, 6);
        do_latch(4'b1110, 1'b0, 1'b0, "short");
        chk("short.err_const", 32'(err), ERR_EN ? 32'd1 : 32'd0);
        pulse_clr();

        // unknown pattern, then bad select
        send_bits(8'h81, 8);
        do_latch(4'b1110, 1'b0, 1'b0, "badpat");
        chk("badpat.digit_const", 32'(digit), 32'hF);
        chk("badpat.err_const", 32'(err), ERR_EN ? 32'd2 : 32'd0);
        saved = disnum;
        send_bits(8'h60, 8);
        do_latch(4'b1100, 1'b0, 1'b0, "badsel");
        chk("badsel.err_const", 32'(err), ERR_EN ? 32'd6 : 32'd0);
        chk("badsel.disnum_const", 32'(disnum),
            ERR_EN ? 32'(saved) : 32'({saved[15:4], 4'h1}));

        // reset in the middle of a byte
        send_bits(8'h55, 3);
        reset_dut("midreset");
        send_bits(8'h60, 8);
        do_latch(4'b1101, 1'b0, 1'b0, "after_rst");
        chk("after_rst.disnum_const", 32'(disnum), 32'h0010);

        // coincident SCLK and RCLK rises
        send_bits(8'hFE, 8);
        do_latch(4'b1110, 1'b1, 1'b1, "simul");
        chk("simul.seg_const", 32'(seg_raw), 32'hFE);
        send_bits(8'h3C, 7);
        do_latch(4'b1101, 1'b0, 1'b0, "simul_next");
        chk("simul_next.badcnt", 32'(err[0]), 32'd0);

        // randomized traffic
        for (int it = 0; it < 40; it++) begin
            pat = ($urandom_range(0, 3) != 0) ? pats[$urandom_range(0, 13)] : 8'($urandom);
            if ($urandom_range(0, 6) != 0)
                sel = ~(4'b0001 << $urandom_range(0, 3));
            else
                sel = 4'($urandom);
            nb = ($urandom_range(0, 4) != 0) ? 8 : int'($urandom_range(0, 12));
            ws = ($urandom_range(0, 9) == 0);
            send_bits(pat, nb);
            do_latch(sel, ws, 1'($urandom), $sformatf("rnd%0d", it));
            if ($urandom_range(0, 4) == 0) pulse_clr();
        end

        repeat (4) @(negedge clk);
        chk("total_dv", 32'(dv_cnt), 32'(m_dv_cnt));
        chk("total_fv", 32'(fv_cnt), 32'(m_fv_cnt));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_capture.md
# seg_capture

Serial 7-segment display stream receiver: the receive end of the SER/SCLK/RCLK/SEL interface the display scan driver produces for its 74HC595-style segment shifter. It oversamples the four display pins on a fast system clock, shifts in 8-bit segment bytes, latches them on RCLK, decodes each byte back to a 4-bit digit code, and reassembles the 16-bit `disnum` word. It sits in the test and monitor path (loopback check of the display driver, on-chip readback of what the FM/AM front panel is showing).

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth on SER/SCLK/RCLK/SEL, legal values 2..3.
- `clk`  in  1  system clock, at least 8× the SCLK toggle rate.
- `rst`  in  1  asynchronous, active-high reset.
- `SER`  in  1  serial segment data, segment bit 0 first.
- `SCLK`  in  1  shift clock; data is sampled on its rising edge.
- `RCLK`  in  1  latch strobe; the rising edge latches the byte.
- `SEL`  in  4  active-low one-hot digit select; `SEL[i]=0` means position i.
- `err_clr`  in  1  single-cycle clear of the sticky error flags.
- `seg_raw`  out  8  last latched segment byte.
- `digit`  out  4  decoded code of the last latched byte.
- `digit_pos`  out  2  position of the last latched byte.
- `digit_valid`  out  1  one-cycle pulse when the previous three outputs update.
- `disnum`  out  16  assembled word; nibble i holds position i.
- `frame_valid`  out  1  one-cycle pulse when all four positions have been captured since the last pulse.
- `err`  out  3  sticky flags: {bad_sel, bad_pattern, bad_count}.

## Operation
- Input sync: SER, SCLK, RCLK and SEL each pass through a `SYNC_STAGES`-flop synchronizer. A further register on SCLK and on RCLK provides rising-edge detect.
- Shift: on a detected SCLK rise, `sr <= {SER_s, sr[7:1]}`. After 8 shifts, `sr[k]` holds segment bit k.
- Bit counter: 4 bits, incremented on each SCLK rise, saturates at 15, reset to 0 by the RCLK latch.
- Latch: on a detected RCLK rise:
  - `seg_raw <= sr`.
  - `digit_pos` is set from the synchronized SEL.
  - `digit` is set from the decode below.
  - `disnum[4*pos +: 4] <= digit`.
  - The seen-mask bit for `pos` is set.
  - The bit counter is cleared.
- Decode: FC→0, 60→1, DA→2, F2→3, 66→4, B6→5, BE→6, E0→7, FE→8, F6→9, EE→A, 6E→B, 9C→C, 00→F (blank). Any other byte decodes to F and flags bad_pattern.
- SEL not one-hot-low at latch: flag bad_sel, keep the previous `digit_pos`, skip the `disnum` and seen-mask update, and suppress `digit_valid`.
- Bit count not equal to 8 at latch: flag bad_count. The byte is still latched and decoded.
- Frame: when the seen mask reaches 4'b1111, pulse `frame_valid` and clear the mask in the same cycle.
- Simultaneous SCLK and RCLK rises: the latch takes the pre-shift `sr`, the shift applies, and the bit counter becomes 1.
- `err_clr` coinciding with a new error: the new error wins and the bit stays set.

## Timing
- Reset value of every output is 0. The seen mask, `sr` and the bit counter also reset to 0.
- Pin edge to internal update (SYNC_STAGES=2): the shift or latch register updates on the 3rd rising `clk` edge after the pin transition.
- Latch to outputs: `digit`, `digit_pos`, `seg_raw`, `disnum`, and the `digit_valid` pulse all update on the 4th edge.
- `frame_valid`: asserted in the same cycle as the `digit_valid` that completes the mask.
- `err`: set in the same cycle as `digit_valid`.
- Each additional sync stage adds 1 cycle.
- Reset mid-byte: the partial byte is discarded. The first RCLK after reset with fewer than 8 shifts flags bad_count.

## Configuration
- `SEG_CAPTURE_ERR_EN` defined: the error checks, `err` flags and `err_clr` function as described.
- Not defined:
  - `err` is tied to 0 and `err_clr` is ignored.
  - A bad SEL is treated as position 0 and updates normally.
  - Unknown patterns still decode to F.

## Test plan
- Shift the bits of B6 LSB first, then raise RCLK with SEL=1011: `digit`=5, `digit_pos`=2, `disnum`=0x0500, one `digit_valid` pulse, `err`=0.
- Send digits 1,2,3,4 to positions 0,1,2,3: `disnum`=0x4321, exactly one `frame_valid` pulse, coinciding with the 4th `digit_valid`.
- Send 6 bits then RCLK: `err`=3'b001. Then pulse `err_clr`: `err` returns to 0.
- Send byte 0x81 with SEL=1110: `digit`=F, `err`=3'b010. Send SEL=1100: `err` bit 2 sets and `disnum` is unchanged.
- Assert `rst` after 3 shifts of a byte: all outputs read 0. A full byte 60 at position 1 afterwards gives `disnum`=0x0010.
- Raise SCLK and RCLK in the same `clk` cycle: `seg_raw` equals the prior 8-bit content, and the bit counter reads 1.
